reg_share_arb: RTL and testbench
================================

Name: reg_share_arb

Overview:
- Round-robin arbiter and controller for one shared WIDTH-bit storage register built from async-reset D flip-flops.
- Up to NREQ requesters use a req/gnt handshake; only the current owner can write the register.
- A hold counter forces release so that no requester can starve the others.
- Sits between requester logic and the shared register. q is the register output and goes to every consumer.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, width of the shared register in bits
- MAX_HOLD, 8, maximum number of cycles one owner may hold the grant (1..255)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_h  input  1  asynchronous, active-high reset
- req  input  NREQ  request per requester; level, held for the whole ownership period
- wen  input  NREQ  write enable per requester
- wdata  input  NREQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, registered; all zero when idle
- owner  output  $clog2(NREQ)  index of current owner; valid only while busy=1
- busy  output  1  high while any grant is active
- q  output  WIDTH  shared register contents
- timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Reset (rst_h=1, asynchronous):
  - gnt=0, owner=0, busy=0, q=0, timeout=0.
  - Hold counter=0, state=IDLE.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - Reset mid-ownership drops the grant immediately, with no extra cycle.
- States: IDLE, OWNED.
- IDLE:
  - If any req bit is high at an edge, grant the first requester found searching from the pointer upward, wrapping modulo NREQ.
  - On that same edge: gnt one-hot set, owner set, busy=1, counter=0, state becomes OWNED.
  - Grant latency is one cycle: req seen at edge k gives gnt high after edge k.
- OWNED, register write:
  - Each edge where req[owner]=1 and wen[owner]=1, q loads wdata slice [owner].
  - Non-owner wen is ignored.
  - wen with req dropped is ignored.
- OWNED, counter:
  - Increments by 1 each edge while held.
  - Saturates at MAX_HOLD.
- OWNED, normal release:
  - Taken at the first edge where req[owner]=0.
  - gnt=0, busy=0, state becomes IDLE, pointer becomes (owner+1) mod NREQ.
  - No write occurs on that edge.
- OWNED, forced release:
  - Taken at the edge where the counter reaches MAX_HOLD-1 and req[owner] is still 1.
  - The owner has held for exactly MAX_HOLD cycles.
  - The write is still honoured on that edge if wen[owner]=1.
  - Then gnt=0, busy=0, timeout=1 for one cycle, pointer becomes owner+1, state becomes IDLE.
- Every release passes through at least one IDLE cycle (gnt=0) before the next grant. Minimum re-grant gap is one cycle.
- Simultaneous requests: the round-robin pointer alone decides; there are no fixed priorities after reset.
- After a forced release, a released requester that still requests is re-granted only if no other req is high, or when its turn comes round again.
- A req pulse that rises and falls between edges is not seen.
- owner holds its last value while idle; consumers qualify it with busy.
- q holds its value across releases and ownership changes; only reset or a write changes it.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined: hold counter, forced release and timeout pulse behave as above.
- Not defined:
  - No hold counter is built; MAX_HOLD is unused.
  - An owner keeps the grant until it drops req.
  - timeout is tied to 0.
  - All other behaviour is unchanged.

Test Plan:
- Reset with stimulus held: rst_h=1 mid-cycle while gnt=4'b0010 and q=8'hA5 -> gnt, busy, q and timeout go to 0 immediately without a clock edge. After release, req=4'b1111 -> gnt=4'b0001 one edge later.
- Round-robin fairness: req=4'b1111 held, each owner drops req 3 cycles after its grant and re-raises it next cycle -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
- Write ownership: owner=2, wen=4'b0101, wdata slice2=8'h3C, slice0=8'hFF -> q=8'h3C after the edge. Next edge, wen=4'b0001 only -> q stays 8'h3C.
- Forced release (ARB_TIMEOUT_EN, MAX_HOLD=8): req[1] held alone -> gnt[1] high exactly 8 cycles, then timeout=1 for 1 cycle and gnt=0 for 1 cycle, then gnt[1] is re-granted. With req[3] also high, gnt[3] is granted next instead.
- Timeout compiled out: req[1] held 50 cycles with req[3] high -> gnt[1] stays high for all 50 and timeout is never 1. req[1] dropped -> gnt[3] one cycle after the IDLE cycle.
- Wrap-around: pointer=3 (last owner 2), req=4'b1001 -> gnt=4'b1000. After it releases, pointer=0 and gnt=4'b0001.

Source files
------------

// File: rtl/reg_share_arb_if.sv
// reg_share_arb_if: requester-side req/wen/wdata and grant/status/q bundle for reg_share_arb
interface reg_share_arb_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int OW = $clog2(NREQ);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       wen;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [OW-1:0]         owner;
  logic                  busy;
  logic [WIDTH-1:0]      q;
  logic                  timeout;
  modport master (output req, wen, wdata, input gnt, owner, busy, q, timeout);
  modport slave  (input req, wen, wdata, output gnt, owner, busy, q, timeout);
endinterface

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin owner arbitration of one shared register; ARB_TIMEOUT_EN adds forced release after MAX_HOLD cycles
module reg_share_arb #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input logic           clk,
  input logic           rst_h,
  reg_share_arb_if.slave bus
);
  localparam int OW = $clog2(NREQ);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d, ptr_q, ptr_d, pick, nxt, idx;
  logic [WIDTH-1:0] q_q, q_d;
  logic             found;
  int               s;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic             to_q, to_d;
`endif
  // Scan downward so the lowest offset from the pointer wins
  always_comb begin
    pick  = '0;
    found = 1'b0;
    s     = 0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = int'(ptr_q) + k;
      if (s >= NREQ) s = s - NREQ;
      idx = OW'(s);
      if (bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
  assign nxt = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    q_d     = q_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    if (state_q == IDLE) begin
      if (found) begin
        state_d = OWNED;
        gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
        owner_d = pick;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
    end else if (!bus.req[owner_q]) begin
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = nxt;
    end else begin
      if (bus.wen[owner_q]) q_d = bus.wdata[owner_q*WIDTH +: WIDTH];
`ifdef ARB_TIMEOUT_EN
      if (cnt_q == 8'(MAX_HOLD - 1)) begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = nxt;
        to_d    = 1'b1;
      end else if (cnt_q != 8'(MAX_HOLD)) begin
        cnt_d = cnt_q + 1'b1;
      end
`endif
    end
  end
  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      q_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end
  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == OWNED);
  assign bus.q     = q_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_reg_share_arb.sv
// tb_reg_share_arb: scoreboard bench; per-edge expectations from a behavioural model, plus directed scenario checks
module tb_reg_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int MH   = 8;
  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [1:0]      owner;
    logic            busy;
    logic [W-1:0]    q;
    logic            to;
  } exp_t;
  logic clk = 1'b0;
  logic rst_h;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic [NREQ-1:0] m_gnt;
  logic [1:0]      m_owner, m_ptr;
  logic            m_busy, m_to;
  logic [W-1:0]    m_q;
  int              m_cnt;
  reg_share_arb_if #(.NREQ(NREQ), .WIDTH(W)) bus ();
  reg_share_arb #(.NREQ(NREQ), .WIDTH(W), .MAX_HOLD(MH)) dut (.clk(clk), .rst_h(rst_h), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_gnt = '0; m_owner = '0; m_ptr = '0; m_busy = 1'b0; m_to = 1'b0; m_q = '0; m_cnt = 0;
  endtask
  task automatic m_edge();
    int i;
    bit hit;
    m_to = 1'b0;
    if (!m_busy) begin
      hit = 0;
      for (int k = 0; k < NREQ; k++) begin
        i = (int'(m_ptr) + k) % NREQ;
        if (!hit && bus.req[i]) begin
          hit = 1; m_busy = 1'b1; m_owner = 2'(i); m_gnt = 4'(1 << i); m_cnt = 0;
        end
      end
    end else if (!bus.req[m_owner]) begin
      m_busy = 1'b0; m_gnt = '0; m_ptr = 2'((int'(m_owner) + 1) % NREQ);
    end else begin
      if (bus.wen[m_owner]) m_q = bus.wdata[int'(m_owner)*W +: W];
`ifdef ARB_TIMEOUT_EN
      if (m_cnt == MH - 1) begin
        m_busy = 1'b0; m_gnt = '0; m_to = 1'b1; m_ptr = 2'((int'(m_owner) + 1) % NREQ);
      end else if (m_cnt < MH) m_cnt++;
`endif
    end
  endtask
  task automatic tick();
    exp_t e;
    m_edge();
    e.gnt = m_gnt; e.owner = m_owner; e.busy = m_busy; e.q = m_q; e.to = m_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("gnt", 32'(bus.gnt), 32'(e.gnt));
    check("owner", 32'(bus.owner), 32'(e.owner));
    check("busy", 32'(bus.busy), 32'(e.busy));
    check("q", 32'(bus.q), 32'(e.q));
    check("timeout", 32'(bus.timeout), 32'(e.to));
  endtask
  initial begin
    int hold, lim;
    rst_h = 1'b1;
    bus.req = '0; bus.wen = '0; bus.wdata = '0;
    m_reset();
    #12;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_q", 32'(bus.q), 0);
    rst_h = 1'b0;
    @(posedge clk); #1;
    // build gnt=0010, q=A5, then async reset mid-cycle
    bus.req = 4'b0010; tick();
    bus.wen = 4'b0010; bus.wdata = 32'h00_00_A5_00; tick();
    check("pre_rst_q", 32'(bus.q), 32'hA5);
    bus.wen = '0;
    #2 rst_h = 1'b1;
    #1;
    check("arst_gnt", 32'(bus.gnt), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_q", 32'(bus.q), 0);
    check("arst_to", 32'(bus.timeout), 0);
    m_reset();
    #1 rst_h = 1'b0;
    bus.req = 4'b1111; tick();
    check("post_rst_gnt", 32'(bus.gnt), 32'b0001);
    // round robin: drop 3 cycles after grant, re-raise next cycle
    for (int n = 0; n < 5; n++) begin
      int o;
      o = int'(bus.owner);
      check("rr_order", 32'(o), 32'(n % NREQ));
      tick(); tick();
      bus.req[o] = 1'b0; tick();
      check("rr_idle", 32'(bus.gnt), 0);
      bus.req[o] = 1'b1; tick();
    end
    bus.req = '0; tick(); tick();
    // write ownership with owner 2
    bus.req = 4'b0100; tick();
    check("wr_owner", 32'(bus.owner), 2);
    bus.wen = 4'b0101; bus.wdata = 32'h00_3C_00_FF; tick();
    check("wr_q", 32'(bus.q), 32'h3C);
    bus.wen = 4'b0001; tick();
    check("wr_nonowner", 32'(bus.q), 32'h3C);
    bus.req = '0; bus.wen = 4'b0100; bus.wdata = 32'h00_77_00_00; tick();
    check("wr_reqdrop", 32'(bus.q), 32'h3C);
    bus.wen = '0;
    // wrap-around from pointer 3
    bus.req = 4'b1001; tick();
    check("wrap_gnt3", 32'(bus.gnt), 32'b1000);
    bus.req = 4'b0001; tick(); tick();
    check("wrap_gnt0", 32'(bus.gnt), 32'b0001);
    bus.req = '0; tick(); tick();
    // pointer now 1: requester 1 alone
    bus.req = 4'b0010; tick();
`ifdef ARB_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      hold = 0; lim = 0;
      while (bus.gnt[1] && lim < 20) begin hold++; lim++; tick(); end
      check("hold_len", 32'(hold), MH);
      check("to_pulse", 32'(bus.timeout), 1);
      if (r == 0) begin
        tick();
        check("regrant1", 32'(bus.gnt), 32'b0010);
        check("to_clear", 32'(bus.timeout), 0);
        bus.req = 4'b1010;
      end else begin
        tick();
        check("next_gnt3", 32'(bus.gnt), 32'b1000);
      end
    end
`else
    bus.req = 4'b1010;
    hold = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (bus.gnt == 4'b0010 && !bus.timeout) hold++;
    end
    check("hold_50", 32'(hold), 50);
    bus.req = 4'b1000; tick();
    check("idle_gap", 32'(bus.gnt), 0);
    tick();
    check("next_gnt3", 32'(bus.gnt), 32'b1000);
`endif
    bus.req = '0; tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
